conv1d_param_loader: RTL and testbench
======================================

CONV1D_PARAM_LOADER -- requirements
Module: conv1d_param_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one weight or bias word.
REQ-002 SHALL have parameter NUM_FILTERS, default 32: number of filters (RAM depth).
REQ-003 SHALL have parameter FILTER_SIZE, default 5: taps per filter.
REQ-004 SHALL have parameter RAM_LATENCY, default 1: cycles from address/rden to valid q; range 1..4.
REQ-005 SHALL have port clk  in  1  the single clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port reload_req  in  1  single-cycle request to re-read all parameters.
REQ-008 SHALL have port datapath_idle  in  1  high when no samples are in flight in the conv1d array.
REQ-009 SHALL have port ram_address  out  clog2(NUM_FILTERS)  shared address to weight and bias RAMs.
REQ-010 SHALL have port ram_rden  out  1  read enable to both RAMs.
REQ-011 SHALL have port weight_ram_q  in  DATA_WIDTH*FILTER_SIZE  weight RAM read data.
REQ-012 SHALL have port bias_ram_q  in  DATA_WIDTH  bias RAM read data.
REQ-013 SHALL have port param_wr_en  out  1  write strobe to per-filter parameter registers.
REQ-014 SHALL have port param_wr_filter  out  clog2(NUM_FILTERS)  filter index being written.
REQ-015 SHALL have port param_wr_weights  out  DATA_WIDTH*FILTER_SIZE  tap-ordered weights.
REQ-016 SHALL have port param_wr_bias  out  DATA_WIDTH  bias word.
REQ-017 SHALL have port params_valid  out  1  all filters loaded; gates the layer ready_in.
REQ-018 SHALL have port loader_busy  out  1  high in any state except READY.
REQ-019 SHALL have port load_count  out  8  completed loads, saturating at 255.

Function
REQ-020 SHALL implement states LOAD, FLUSH, WAIT_IDLE and READY.
REQ-021 LOAD SHALL assert ram_rden and issue addresses 0..NUM_FILTERS-1, one per cycle, then go to FLUSH.
REQ-022 SHALL tag each issued read with valid+index through a RAM_LATENCY-deep shift register; param_wr_en/param_wr_filter SHALL be its output (write for address i in cycle i+RAM_LATENCY after LOAD entry).
REQ-023 param_wr_weights tap k SHALL equal weight_ram_q[(FILTER_SIZE-1-k)*DATA_WIDTH +: DATA_WIDTH] (MSB word is tap 0); param_wr_bias SHALL equal bias_ram_q; both are combinational pass-through.
REQ-024 FLUSH SHALL hold ram_rden low and exit once the tag pipeline is empty: to READY if no reload is pending, else to WAIT_IDLE.
REQ-025 params_valid SHALL rise in cycle NUM_FILTERS+RAM_LATENCY after LOAD entry, exactly one cycle after the last write.
REQ-026 In READY, reload_req SHALL clear params_valid in the next cycle and go to WAIT_IDLE.
REQ-027 WAIT_IDLE SHALL go to LOAD in the first cycle datapath_idle is high, restarting at address 0.
REQ-028 reload_req during LOAD/FLUSH/WAIT_IDLE SHALL set a sticky pending flag; pending SHALL clear on LOAD entry; multiple requests SHALL coalesce into one reload.
REQ-029 load_count SHALL increment on each FLUSH exit and saturate at 255.
REQ-030 ram_address SHALL hold its last value when ram_rden is low.
REQ-031 NUM_FILTERS=1 SHALL work: one read, one write, no wrap of the address counter.

Reset
REQ-032 While rst=0: params_valid=0, param_wr_en=0, ram_rden=0, ram_address=0, param_wr_filter=0, load_count=0, tag pipeline cleared, pending=0, loader_busy=1.
REQ-033 First cycle after rst rises SHALL be LOAD with address 0; datapath_idle is not checked.
REQ-034 Reset mid-load SHALL discard in-flight reads (no param_wr_en for them) and restart from address 0.

Structure
REQ-035 The state enum and clog2 SHALL live in cnn1d_pkg; the tag shift register SHALL be a sub-module conv1d_param_tag_pipe (parameters DEPTH, INDEX_WIDTH).

Verification (DATA_WIDTH=8, FILTER_SIZE=3, NUM_FILTERS=4, RAM_LATENCY=1 unless stated)
REQ-036 Reset release, weight RAM word 0 = 0x010203 -> writes in cycles 1..4, filter 0 taps {0x01,0x02,0x03}, params_valid=1 in cycle 5, load_count=1.
REQ-037 reload_req in READY with datapath_idle=0 for 6 cycles -> params_valid=0 next cycle, ram_rden stays 0 until idle, full reload follows, load_count=2.
REQ-038 Three reload_req pulses during LOAD -> exactly one extra load after FLUSH, load_count=2 at end.
REQ-039 rst=0 at cycle 2 of LOAD -> no param_wr_en during reset, next release rewrites filters 0..3 from address 0.
REQ-040 RAM_LATENCY=3 -> writes in cycles 3..6, params_valid=1 in cycle 7.
REQ-041 NUM_FILTERS=1 -> single write in cycle 1, params_valid=1 in cycle 2.

Source files
------------

// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the conv1d parameter path.
package cnn1d_pkg;

    typedef enum logic [1:0] {
        ST_LOAD      = 2'd0,
        ST_FLUSH     = 2'd1,
        ST_WAIT_IDLE = 2'd2,
        ST_READY     = 2'd3
    } loader_state_e;

    // Never returns less than 1 so a single-entry RAM still gets a 1-bit address.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/conv1d_param_tag_pipe.sv
// Shift register that carries valid+index alongside each RAM read so the
// write strobe lines up with the returning read data.
module conv1d_param_tag_pipe #(
    parameter int DEPTH       = 1,
    parameter int INDEX_WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [INDEX_WIDTH-1:0] in_index,
    output logic                   out_valid,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic                   drain_done
);

    logic [DEPTH-1:0]       valid_q;
    logic [INDEX_WIDTH-1:0] index_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) index_q[i] <= '0;
        end else begin
            valid_q[0] <= in_valid;
            index_q[0] <= in_index;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                index_q[i] <= index_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_index = index_q[DEPTH-1];

    // True when nothing will remain in flight after the current edge.
    always_comb begin
        drain_done = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (valid_q[i]) drain_done = 1'b0;
        end
    end

endmodule

// File: rtl/conv1d_param_loader.sv
// Streams every filter's weights and bias from RAM into the per-filter
// registers after reset and on request, once the datapath has drained.
module conv1d_param_loader
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_FILTERS = 32,
    parameter int FILTER_SIZE = 5,
    parameter int RAM_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              reload_req,
    input  logic                              datapath_idle,
    output logic [clog2(NUM_FILTERS)-1:0]     ram_address,
    output logic                              ram_rden,
    input  logic [DATA_WIDTH*FILTER_SIZE-1:0] weight_ram_q,
    input  logic [DATA_WIDTH-1:0]             bias_ram_q,
    output logic                              param_wr_en,
    output logic [clog2(NUM_FILTERS)-1:0]     param_wr_filter,
    output logic [DATA_WIDTH*FILTER_SIZE-1:0] param_wr_weights,
    output logic [DATA_WIDTH-1:0]             param_wr_bias,
    output logic                              params_valid,
    output logic                              loader_busy,
    output logic [7:0]                        load_count,
    output loader_state_e                     dbg_state
);

    localparam int            AW        = clog2(NUM_FILTERS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_FILTERS - 1);

    loader_state_e state;
    logic          pending;
    logic          drain_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_LOAD;
            ram_rden     <= 1'b0;
            ram_address  <= '0;
            pending      <= 1'b0;
            params_valid <= 1'b0;
            load_count   <= 8'd0;
        end else begin
            if (reload_req && state != ST_READY) pending <= 1'b1;
            case (state)
                ST_LOAD: begin
                    // rden low inside LOAD only happens on the edge leaving reset.
                    if (!ram_rden) begin
                        ram_rden    <= 1'b1;
                        ram_address <= '0;
                    end else if (ram_address == LAST_ADDR) begin
                        ram_rden <= 1'b0;
                        state    <= ST_FLUSH;
                    end else begin
                        ram_address <= ram_address + AW'(1);
                    end
                end
                ST_FLUSH: begin
                    if (drain_done) begin
                        if (load_count != 8'hFF) load_count <= load_count + 8'd1;
                        if (pending || reload_req) begin
                            state <= ST_WAIT_IDLE;
                        end else begin
                            state        <= ST_READY;
                            params_valid <= 1'b1;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (datapath_idle) begin
                        state       <= ST_LOAD;
                        ram_rden    <= 1'b1;
                        ram_address <= '0;
                        pending     <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (reload_req) begin
                        params_valid <= 1'b0;
                        state        <= ST_WAIT_IDLE;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    conv1d_param_tag_pipe #(
        .DEPTH       (RAM_LATENCY),
        .INDEX_WIDTH (AW)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (ram_rden),
        .in_index   (ram_address),
        .out_valid  (param_wr_en),
        .out_index  (param_wr_filter),
        .drain_done (drain_done)
    );

    // RAM stores tap 0 in the most significant word; registers want tap k at slice k.
    always_comb begin
        param_wr_weights = '0;
        for (int k = 0; k < FILTER_SIZE; k++) begin
            param_wr_weights[k*DATA_WIDTH +: DATA_WIDTH] =
                weight_ram_q[(FILTER_SIZE-1-k)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign param_wr_bias = bias_ram_q;
    assign loader_busy   = (state != ST_READY);
    assign dbg_state     = state;

endmodule

// File: tb/tb_conv1d_param_loader.sv
// Bench for conv1d_param_loader: three configurations side by side
// (4 filters/latency 1, 4 filters/latency 3, 1 filter/latency 1).
module tb_conv1d_param_loader;
  import cnn1d_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_cmp;
  int n_err;

  // ---------------- instance signals ----------------
  logic reload_a, idle_a, rden_a, wen_a, pv_a, busy_a;
  logic [1:0] addr_a, wf_a;
  logic [23:0] wq_a, ww_a;
  logic [7:0] bq_a, wb_a, lc_a;
  loader_state_e st_a;

  logic reload_b, idle_b, rden_b, wen_b, pv_b, busy_b;
  logic [1:0] addr_b, wf_b;
  logic [23:0] wq_b, ww_b;
  logic [7:0] bq_b, wb_b, lc_b;
  loader_state_e st_b;

  logic reload_c, idle_c, rden_c, wen_c, pv_c, busy_c;
  logic [0:0] addr_c, wf_c;
  logic [23:0] wq_c, ww_c;
  logic [7:0] bq_c, wb_c, lc_c;
  loader_state_e st_c;

  conv1d_param_loader #(.DATA_WIDTH(8), .NUM_FILTERS(4), .FILTER_SIZE(3), .RAM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .reload_req(reload_a), .datapath_idle(idle_a),
    .ram_address(addr_a), .ram_rden(rden_a), .weight_ram_q(wq_a), .bias_ram_q(bq_a),
    .param_wr_en(wen_a), .param_wr_filter(wf_a), .param_wr_weights(ww_a), .param_wr_bias(wb_a),
    .params_valid(pv_a), .loader_busy(busy_a), .load_count(lc_a), .dbg_state(st_a));

  conv1d_param_loader #(.DATA_WIDTH(8), .NUM_FILTERS(4), .FILTER_SIZE(3), .RAM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .reload_req(reload_b), .datapath_idle(idle_b),
    .ram_address(addr_b), .ram_rden(rden_b), .weight_ram_q(wq_b), .bias_ram_q(bq_b),
    .param_wr_en(wen_b), .param_wr_filter(wf_b), .param_wr_weights(ww_b), .param_wr_bias(wb_b),
    .params_valid(pv_b), .loader_busy(busy_b), .load_count(lc_b), .dbg_state(st_b));

  conv1d_param_loader #(.DATA_WIDTH(8), .NUM_FILTERS(1), .FILTER_SIZE(3), .RAM_LATENCY(1)) dut_c (
    .clk(clk), .rst(rst), .reload_req(reload_c), .datapath_idle(idle_c),
    .ram_address(addr_c), .ram_rden(rden_c), .weight_ram_q(wq_c), .bias_ram_q(bq_c),
    .param_wr_en(wen_c), .param_wr_filter(wf_c), .param_wr_weights(ww_c), .param_wr_bias(wb_c),
    .params_valid(pv_c), .loader_busy(busy_c), .load_count(lc_c), .dbg_state(st_c));

  // ---------------- RAM models (taps kept per filter, tap 0 first) ----------------
  logic [7:0] tap [3][4][3];
  logic [7:0] bias_m [3][4];

  function automatic logic [23:0] ram_word(input int id, input int a);
    return {tap[id][a][0], tap[id][a][1], tap[id][a][2]};
  endfunction

  always @(posedge clk) begin
    if (rden_a) begin
      wq_a <= ram_word(0, int'(addr_a));
      bq_a <= bias_m[0][addr_a];
    end
    if (rden_c) begin
      wq_c <= ram_word(2, int'(addr_c));
      bq_c <= bias_m[2][addr_c];
    end
  end

  logic [23:0] bw_p [3];
  logic [7:0]  bb_p [3];
  always @(posedge clk) begin
    bw_p[0] <= rden_b ? ram_word(1, int'(addr_b)) : 24'h0;
    bb_p[0] <= rden_b ? bias_m[1][addr_b] : 8'h0;
    bw_p[1] <= bw_p[0];
    bb_p[1] <= bb_p[0];
    bw_p[2] <= bw_p[1];
    bb_p[2] <= bb_p[1];
  end
  assign wq_b = bw_p[2];
  assign bq_b = bb_p[2];

  task automatic fill_mem(input int id);
    for (int a = 0; a < 4; a++) begin
      for (int k = 0; k < 3; k++) tap[id][a][k] = 8'($urandom_range(0, 255));
      bias_m[id][a] = 8'($urandom_range(0, 255));
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected behaviour of cycle c after LOAD entry, from the load timing rules.
  task automatic check_cycle(input int id, input int c, input int nf, input int lat, input bit pend,
                             input logic rden, input logic en, input logic [7:0] filt,
                             input logic [23:0] w, input logic [7:0] b, input logic pv);
    string tg;
    bit exp_en;
    int f;
    tg = $sformatf("i%0d_c%0d", id, c);
    exp_en = (c >= lat) && (c < nf + lat);
    chk({tg, "_rden"}, rden, (c < nf));
    chk({tg, "_wr_en"}, en, exp_en);
    if (exp_en) begin
      f = c - lat;
      chk({tg, "_filter"}, filt, f);
      chk({tg, "_weights"}, w, {tap[id][f][2], tap[id][f][1], tap[id][f][0]});
      chk({tg, "_bias"}, b, bias_m[id][f]);
    end
    chk({tg, "_pvalid"}, pv, (c == nf + lat) && !pend);
  endtask

  // First negedge inside the task is cycle 0 of LOAD.
  task automatic run_load(input int id, input bit pend, input logic [7:0] mask, input int last_c);
    int nf;
    int lat;
    int stop;
    nf = (id == 2) ? 1 : 4;
    lat = (id == 1) ? 3 : 1;
    stop = (last_c < 0) ? nf + lat : last_c;
    for (int c = 0; c <= stop; c++) begin
      @(negedge clk);
      case (id)
        0: check_cycle(0, c, nf, lat, pend, rden_a, wen_a, 8'(wf_a), ww_a, wb_a, pv_a);
        1: check_cycle(1, c, nf, lat, pend, rden_b, wen_b, 8'(wf_b), ww_b, wb_b, pv_b);
        default: check_cycle(2, c, nf, lat, pend, rden_c, wen_c, 8'(wf_c), ww_c, wb_c, pv_c);
      endcase
      if (id == 0) reload_a = (c < 8) ? mask[c] : 1'b0;
    end
  endtask

  task automatic load_all_after_release();
    fork
      run_load(0, 1'b0, 8'h00, -1);
      run_load(1, 1'b0, 8'h00, -1);
      run_load(2, 1'b0, 8'h00, -1);
    join
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int timeouts;
    bit to;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    reload_a = 1'b0; reload_b = 1'b0; reload_c = 1'b0;
    idle_a = 1'b1; idle_b = 1'b1; idle_c = 1'b1;
    for (int id = 0; id < 3; id++) fill_mem(id);
    tap[0][0][0] = 8'h01; tap[0][0][1] = 8'h02; tap[0][0][2] = 8'h03;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_pvalid_a", pv_a, 0);
    chk("rst_wr_en_a", wen_a, 0);
    chk("rst_rden_a", rden_a, 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_filter_a", wf_a, 0);
    chk("rst_count_a", lc_a, 0);
    chk("rst_busy_a", busy_a, 1);
    chk("rst_wr_en_b", wen_b, 0);
    chk("rst_busy_b", busy_b, 1);
    chk("rst_rden_c", rden_c, 0);
    chk("rst_busy_c", busy_c, 1);

    // first load after reset release, all three configurations
    rst = 1'b1;
    load_all_after_release();
    chk("first_count_a", lc_a, 1);
    chk("first_count_b", lc_b, 1);
    chk("first_count_c", lc_c, 1);
    chk("first_busy_a", busy_a, 0);
    chk("first_state_a", st_a, ST_READY);
    chk("first_addr_hold_a", addr_a, 3);
    chk("first_pvalid_b", pv_b, 1);

    // reload while the datapath is still busy
    @(negedge clk);
    reload_a = 1'b1;
    idle_a = 1'b0;
    @(negedge clk);
    reload_a = 1'b0;
    chk("rel_pvalid_drop", pv_a, 0);
    chk("rel_busy", busy_a, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rel_wait_rden_%0d", i), rden_a, 0);
      chk($sformatf("rel_wait_addr_%0d", i), addr_a, 3);
    end
    idle_a = 1'b1;
    fill_mem(0);
    run_load(0, 1'b0, 8'h00, -1);
    chk("rel_count", lc_a, 2);

    // three reload pulses during LOAD coalesce into a single extra load
    @(negedge clk);
    reload_a = 1'b1;
    @(negedge clk);
    reload_a = 1'b0;
    fill_mem(0);
    run_load(0, 1'b1, 8'b0000_1101, -1);
    fill_mem(0);
    run_load(0, 1'b0, 8'h00, -1);
    repeat (3) @(negedge clk);
    chk("coalesce_count", lc_a, 4);
    chk("coalesce_pvalid", pv_a, 1);
    chk("coalesce_busy", busy_a, 0);

    // reset in cycle 2 of a load discards in-flight reads
    reload_a = 1'b1;
    @(negedge clk);
    reload_a = 1'b0;
    fill_mem(0);
    run_load(0, 1'b0, 8'h00, 2);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_wr_en_%0d", i), wen_a, 0);
      chk($sformatf("midrst_rden_%0d", i), rden_a, 0);
      chk($sformatf("midrst_pvalid_%0d", i), pv_a, 0);
    end
    chk("midrst_count", lc_a, 0);
    for (int id = 0; id < 3; id++) fill_mem(id);
    rst = 1'b1;
    load_all_after_release();
    chk("midrst_count_a", lc_a, 1);
    chk("midrst_count_b", lc_b, 1);
    chk("midrst_count_c", lc_c, 1);

    // load_count saturation on the single-filter instance
    timeouts = 0;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      reload_c = 1'b1;
      @(negedge clk);
      reload_c = 1'b0;
      to = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (!busy_c) begin
          to = 1'b0;
          break;
        end
      end
      if (to) timeouts++;
      if (i == 199) chk("sat_count_201", lc_c, 201);
    end
    chk("sat_timeouts", timeouts, 0);
    chk("sat_count_255", lc_c, 255);
    chk("sat_pvalid_c", pv_c, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed still running, expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
